// File: rtl/iccm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : iccm_arbiter
//  Purpose  : Arbitrates the single ICCM port between the instruction fetch
//             unit (IFU, read only) and the load/store unit (LSU). The LSU has
//             priority, but a starvation counter forces an IFU grant once the
//             LSU has won STARVE_MAX consecutive contended cycles. Grants are
//             combinational in the request cycle; responses return exactly one
//             cycle later to the owner recorded in a registered tag.
//  Ports    :
//    clk, rst_n                     clock, async active-low reset
//    ifu_req_i/ifu_addr_i           IFU fetch request and byte address
//    ifu_flush_i                    IFU redirect, drops pending IFU response
//    ifu_gnt_o                      IFU request accepted this cycle
//    ifu_rvalid_o/ifu_rdata_o       IFU response valid / instruction word
//    lsu_req_i/lsu_we_i             LSU request, 1 = write
//    lsu_addr_i/lsu_wdata_i/lsu_be_i LSU byte address, write data, byte enables
//    lsu_gnt_o                      LSU request accepted this cycle
//    lsu_rvalid_o/lsu_rdata_o       LSU response valid / read data (0 on write)
//    iccm_en_o/iccm_we_o            ICCM enable / write enable
//    iccm_addr_o/iccm_wdata_o       ICCM word address / write data
//    iccm_be_o                      ICCM byte enables
//    iccm_rdata_i                   ICCM read data, one cycle after read enable
//  Revision : 1.0  initial release
// ============================================================================
module iccm_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  input  logic        ifu_flush_i,
  output logic        ifu_gnt_o,
  output logic        ifu_rvalid_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_be_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        iccm_en_o,
  output logic        iccm_we_o,
  output logic [31:0] iccm_addr_o,
  output logic [31:0] iccm_wdata_o,
  output logic [3:0]  iccm_be_o,
  input  logic [31:0] iccm_rdata_i
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    NORMAL    = 1'b0,
    FORCE_IFU = 1'b1
  } arb_state_e;

  arb_state_e  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        ifu_pend_q, ifu_pend_d;   // IFU response due next cycle
  logic        lsu_pend_q, lsu_pend_d;   // LSU response due next cycle
  logic        lsu_wr_q, lsu_wr_d;       // pending LSU response is a write ack

  logic        ifu_gnt;
  logic        lsu_gnt;
  logic        lsu_wr_gnt;
  logic [31:0] gnt_addr;

  // --------------------------------------------------------------------------
  // Arbitration FSM: next state and grants
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    ifu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;

    // Grants are suppressed while reset is asserted so outputs go quiet
    // immediately rather than at the next clock edge.
    if (rst_n) begin
      unique case (state_q)
        NORMAL: begin
          if (lsu_req_i) begin
            lsu_gnt = 1'b1;
            if (ifu_req_i) begin
              starve_d = starve_q + 4'd1;
              if (starve_d >= STARVE_LIMIT) begin
                state_d = FORCE_IFU;
              end
            end else begin
              starve_d = 4'd0;
            end
          end else begin
            ifu_gnt  = ifu_req_i;
            starve_d = 4'd0;
          end
        end
        FORCE_IFU: begin
          // Either the IFU gets its forced slot or it stopped asking; in both
          // cases the starvation episode is over.
          starve_d = 4'd0;
          state_d  = NORMAL;
          if (ifu_req_i) begin
            ifu_gnt = 1'b1;
          end else begin
            lsu_gnt = lsu_req_i;
          end
        end
        default: begin
          state_d  = NORMAL;
          starve_d = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // ICCM drive: address from the winner with the byte offset masked off;
  // write controls only for a granted LSU write.
  // --------------------------------------------------------------------------
  assign lsu_wr_gnt = lsu_gnt & lsu_we_i;
  assign gnt_addr   = lsu_gnt ? lsu_addr_i : (ifu_gnt ? ifu_addr_i : 32'h0);

  assign ifu_gnt_o    = ifu_gnt;
  assign lsu_gnt_o    = lsu_gnt;
  assign iccm_en_o    = ifu_gnt | lsu_gnt;
  assign iccm_addr_o  = gnt_addr & ~32'h3;
  assign iccm_we_o    = lsu_wr_gnt;
  assign iccm_be_o    = lsu_wr_gnt ? lsu_be_i : 4'h0;
  assign iccm_wdata_o = lsu_wr_gnt ? lsu_wdata_i : 32'h0;

  // --------------------------------------------------------------------------
  // Response tags. A flush in the grant cycle drops the IFU tag up front; a
  // flush in the response cycle masks the already-pending response.
  // --------------------------------------------------------------------------
  assign ifu_pend_d = ifu_gnt & ~ifu_flush_i;
  assign lsu_pend_d = lsu_gnt;
  assign lsu_wr_d   = lsu_wr_gnt;

  assign ifu_rvalid_o = ifu_pend_q & ~ifu_flush_i;
  assign ifu_rdata_o  = ifu_rvalid_o ? iccm_rdata_i : 32'h0;
  assign lsu_rvalid_o = lsu_pend_q;
  assign lsu_rdata_o  = (lsu_pend_q && !lsu_wr_q) ? iccm_rdata_i : 32'h0;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      starve_q   <= 4'd0;
      ifu_pend_q <= 1'b0;
      lsu_pend_q <= 1'b0;
      lsu_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ifu_pend_q <= ifu_pend_d;
      lsu_pend_q <= lsu_pend_d;
      lsu_wr_q   <= lsu_wr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iccm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iccm_arbiter
//  Purpose  : Directed self-checking bench for iccm_arbiter (STARVE_MAX = 4).
//             Inputs change 1 ns after the rising edge; outputs are sampled
//             1 ns later, well clear of the next edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iccm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_i, ifu_flush_i, ifu_gnt_o, ifu_rvalid_o;
  logic [31:0] ifu_addr_i, ifu_rdata_o;
  logic        lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [3:0]  lsu_be_i;
  logic        iccm_en_o, iccm_we_o;
  logic [31:0] iccm_addr_o, iccm_wdata_o, iccm_rdata_i;
  logic [3:0]  iccm_be_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iccm_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_req_i    (ifu_req_i),
    .ifu_addr_i   (ifu_addr_i),
    .ifu_flush_i  (ifu_flush_i),
    .ifu_gnt_o    (ifu_gnt_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .ifu_rdata_o  (ifu_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .iccm_en_o    (iccm_en_o),
    .iccm_we_o    (iccm_we_o),
    .iccm_addr_o  (iccm_addr_o),
    .iccm_wdata_o (iccm_wdata_o),
    .iccm_be_o    (iccm_be_o),
    .iccm_rdata_i (iccm_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_i = 1'b0; ifu_addr_i = 32'h0; ifu_flush_i = 1'b0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = 32'h0;
    lsu_wdata_i = 32'h0; lsu_be_i = 4'h0; iccm_rdata_i = 32'h0;
  endtask

  // Both units request continuously; pattern bit i = 1 means LSU expected,
  // 0 means IFU expected, for cycle i (LSB first).
  task automatic contend(input string tag, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      ifu_req_i = 1'b1; ifu_addr_i = 32'h200;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h300;
      settle();
      check($sformatf("%s_lsu_gnt[%0d]", tag, i), {31'h0, lsu_gnt_o}, {31'h0, pat[i]});
      check($sformatf("%s_ifu_gnt[%0d]", tag, i), {31'h0, ifu_gnt_o}, {31'h0, ~pat[i]});
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    // Reset: requests present but nothing may be granted or driven.
    ifu_req_i = 1'b1; lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'hF;
    settle();
    check("rst_ifu_gnt", {31'h0, ifu_gnt_o}, 32'h0);
    check("rst_lsu_gnt", {31'h0, lsu_gnt_o}, 32'h0);
    check("rst_iccm_en", {31'h0, iccm_en_o}, 32'h0);
    check("rst_iccm_be", {28'h0, iccm_be_o}, 32'h0);
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;

    // Idle: nothing driven, no responses.
    tick();
    iccm_rdata_i = 32'hFFFF_0000;
    settle();
    check("idle_en",     {31'h0, iccm_en_o}, 32'h0);
    check("idle_addr",   iccm_addr_o, 32'h0);
    check("idle_wdata",  iccm_wdata_o, 32'h0);
    check("idle_we_be",  {27'h0, iccm_we_o, iccm_be_o}, 32'h0);
    check("idle_rvalid", {30'h0, ifu_rvalid_o, lsu_rvalid_o}, 32'h0);
    check("idle_rdata",  ifu_rdata_o | lsu_rdata_o, 32'h0);

    // IFU fetch stream 0x0, 0x4, 0x8.
    tick();
    ifu_req_i = 1'b1; ifu_addr_i = 32'h0;
    settle();
    check("ifu0_gnt",  {31'h0, ifu_gnt_o}, 32'h1);
    check("ifu0_en",   {31'h0, iccm_en_o}, 32'h1);
    check("ifu0_addr", iccm_addr_o, 32'h0);
    check("ifu0_we",   {31'h0, iccm_we_o}, 32'h0);
    tick();
    ifu_addr_i = 32'h4; iccm_rdata_i = 32'h1111_1111;
    settle();
    check("ifu1_addr",   iccm_addr_o, 32'h4);
    check("ifu1_rvalid", {31'h0, ifu_rvalid_o}, 32'h1);
    check("ifu1_rdata",  ifu_rdata_o, 32'h1111_1111);
    check("ifu1_lsu_rv", {31'h0, lsu_rvalid_o}, 32'h0);
    tick();
    ifu_addr_i = 32'h8; iccm_rdata_i = 32'h2222_2222;
    settle();
    check("ifu2_addr",   iccm_addr_o, 32'h8);
    check("ifu2_rdata",  ifu_rdata_o, 32'h2222_2222);
    tick();
    ifu_req_i = 1'b0; iccm_rdata_i = 32'h3333_3333;
    settle();
    check("ifu3_gnt",    {31'h0, ifu_gnt_o}, 32'h0);
    check("ifu3_rvalid", {31'h0, ifu_rvalid_o}, 32'h1);
    check("ifu3_rdata",  ifu_rdata_o, 32'h3333_3333);
    tick();
    iccm_rdata_i = 32'h4444_4444;
    settle();
    check("ifu4_rvalid", {31'h0, ifu_rvalid_o}, 32'h0);
    check("ifu4_rdata",  ifu_rdata_o, 32'h0);

    // LSU write with unaligned address.
    tick();
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h103;
    lsu_be_i = 4'b0010; lsu_wdata_i = 32'hAABB_CCDD;
    settle();
    check("wr_gnt",   {31'h0, lsu_gnt_o}, 32'h1);
    check("wr_addr",  iccm_addr_o, 32'h100);
    check("wr_we",    {31'h0, iccm_we_o}, 32'h1);
    check("wr_be",    {28'h0, iccm_be_o}, 32'h2);
    check("wr_wdata", iccm_wdata_o, 32'hAABB_CCDD);
    tick();
    idle_inputs(); iccm_rdata_i = 32'hDEAD_BEEF;
    settle();
    check("wr_ack_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
    check("wr_ack_rdata",  lsu_rdata_o, 32'h0);
    check("wr_ack_ifu_rv", {31'h0, ifu_rvalid_o}, 32'h0);

    // Flush in the response cycle drops IFU data; LSU read unaffected.
    tick();
    idle_inputs(); ifu_req_i = 1'b1; ifu_addr_i = 32'h40;
    settle();
    check("fl_ifu_gnt", {31'h0, ifu_gnt_o}, 32'h1);
    tick();
    ifu_req_i = 1'b0; ifu_flush_i = 1'b1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h80; iccm_rdata_i = 32'h5555_5555;
    settle();
    check("fl_ifu_rvalid", {31'h0, ifu_rvalid_o}, 32'h0);
    check("fl_ifu_rdata",  ifu_rdata_o, 32'h0);
    check("fl_lsu_gnt",    {31'h0, lsu_gnt_o}, 32'h1);
    check("fl_lsu_addr",   iccm_addr_o, 32'h80);
    tick();
    idle_inputs(); iccm_rdata_i = 32'h6666_6666;
    settle();
    check("fl_lsu_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
    check("fl_lsu_rdata",  lsu_rdata_o, 32'h6666_6666);

    // Flush in the grant cycle: grant issued, response never appears.
    tick();
    ifu_req_i = 1'b1; ifu_addr_i = 32'h44; ifu_flush_i = 1'b1;
    settle();
    check("flg_ifu_gnt", {31'h0, ifu_gnt_o}, 32'h1);
    tick();
    idle_inputs(); iccm_rdata_i = 32'h7777_7777;
    settle();
    check("flg_ifu_rvalid", {31'h0, ifu_rvalid_o}, 32'h0);

    // Starvation: L L L L I L L L L I.
    tick();
    contend("starve", 10, 16'b0000_0001_1110_1111);
    idle_inputs();

    // Forced slot abandoned: IFU drops after four LSU wins, LSU alone wins,
    // and the counter starts over.
    contend("abn", 4, 16'h000F);
    lsu_req_i = 1'b1; ifu_req_i = 1'b0;
    settle();
    check("abn_lsu_only", {31'h0, lsu_gnt_o}, 32'h1);
    tick();
    contend("abn2", 5, 16'h000F);
    idle_inputs();

    // Reset the cycle after an LSU read grant that followed two contended wins.
    contend("rstpre", 2, 16'h0003);
    idle_inputs();
    rst_n = 1'b0;
    iccm_rdata_i = 32'h8888_8888;
    settle();
    check("rst_mid_lsu_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
    check("rst_mid_lsu_rdata",  lsu_rdata_o, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    check("rst_post_lsu_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
    tick();
    contend("rstpost", 5, 16'h000F);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Mutual exclusion of grants, checked on every falling edge.
  always @(negedge clk) begin
    if (ifu_gnt_o && lsu_gnt_o) begin
      check("dual_grant", {30'h0, ifu_gnt_o, lsu_gnt_o}, 32'h0);
    end
  end

endmodule
`default_nettype wire

// File: doc/iccm_arbiter.md
ICCM_ARBITER -- requirements
Module: iccm_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive LSU grants while IFU waits (range 1..15).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ifu_req_i  input  1  IFU fetch request (read only).
REQ-005 ifu_addr_i  input  32  IFU fetch byte address.
REQ-006 ifu_flush_i  input  1  IFU redirect; discard pending IFU response.
REQ-007 ifu_gnt_o  output  1  IFU request accepted this cycle.
REQ-008 ifu_rvalid_o / ifu_rdata_o  output  1/32  IFU read response valid / instruction word.
REQ-009 lsu_req_i, lsu_we_i  input  1 each  LSU request; 1 = write.
REQ-010 lsu_addr_i, lsu_wdata_i  input  32 each  LSU byte address, write data.
REQ-011 lsu_be_i  input  4  LSU byte enables (writes only).
REQ-012 lsu_gnt_o, lsu_rvalid_o  output  1 each  LSU accept; LSU response valid.
REQ-013 lsu_rdata_o  output  32  LSU read data.
REQ-014 iccm_en_o, iccm_we_o  output  1 each  ICCM access enable, write enable.
REQ-015 iccm_addr_o, iccm_wdata_o  output  32 each  ICCM word address, write data.
REQ-016 iccm_be_o  output  4  ICCM byte enables.
REQ-017 iccm_rdata_i  input  32  ICCM read data, valid one cycle after an enabled read.

Function
REQ-018 Single shared ICCM port; at most one grant per cycle; ifu_gnt_o and lsu_gnt_o never both 1.
REQ-019 Grant combinational in request cycle; req held until gnt (req/gnt handshake); no grant without req.
REQ-020 Arbitration FSM states: NORMAL, FORCE_IFU.
REQ-021 NORMAL: LSU priority; both requesting -> LSU granted, starve counter +1; counter reaching STARVE_MAX -> FORCE_IFU.
REQ-022 NORMAL: IFU granted, or IFU not requesting -> starve counter cleared to 0.
REQ-023 FORCE_IFU: IFU granted if requesting (LSU waits); on that IFU grant, or if ifu_req_i drops, counter = 0, return NORMAL; LSU alone requesting in FORCE_IFU with ifu_req_i=0 -> granted, return NORMAL.
REQ-024 ICCM drive: iccm_en_o = any grant; iccm_addr_o = granted addr with bits[1:0] forced 0; iccm_we_o/be_o/wdata_o from LSU only when LSU write granted, else 0.
REQ-025 No grant -> iccm_en_o=0, iccm_we_o=0, iccm_be_o=0, iccm_addr_o=0, iccm_wdata_o=0.
REQ-026 Response latency exactly 1 cycle: registered tag records owner of each grant; rvalid asserted to that owner in next cycle only.
REQ-027 LSU write produces lsu_rvalid_o=1 next cycle with lsu_rdata_o=0 (write ack).
REQ-028 ifu_rdata_o / lsu_rdata_o = iccm_rdata_i when own rvalid=1, else 32'h0.
REQ-029 ifu_flush_i=1: IFU grant still issued if requested same cycle, but its response tag marked dropped; pending IFU response (rvalid cycle) suppressed (ifu_rvalid_o=0, ifu_rdata_o=0) when flush coincides.
REQ-030 ifu_flush_i never affects LSU grant, response, or FSM state.
REQ-031 Back-to-back grants every cycle supported; throughput 1 access/cycle.

Reset
REQ-032 rst_n=0: FSM=NORMAL, starve counter=0, response tags cleared; all outputs 0 immediately (async).
REQ-033 Reset mid-access: in-flight response discarded; no rvalid after reset release until new grant.

Verification
REQ-034 Both req held, STARVE_MAX=4 -> lsu_gnt 4 cycles, ifu_gnt cycle 5, then lsu_gnt resumes; no dual grant.
REQ-035 IFU only, addr 0x0,0x4,0x8 consecutive -> ifu_gnt each cycle, iccm_addr 0x0/0x4/0x8, ifu_rvalid one cycle later each with iccm_rdata_i.
REQ-036 LSU write addr 0x103, be 4'b0010, wdata 0xAABBCCDD -> iccm_addr 0x100, we=1, be=0010; next cycle lsu_rvalid=1, lsu_rdata=0.
REQ-037 IFU grant at cycle N, ifu_flush_i=1 at cycle N+1 -> ifu_rvalid_o=0 at N+1; LSU read granted N+1 still returns at N+2.
REQ-038 rst_n asserted cycle after LSU read grant -> lsu_rvalid stays 0; after release, FSM NORMAL, counter 0.
REQ-039 No requests -> iccm_en_o=0, all ICCM outputs 0, no rvalid.
